writeback_stage: RTL
====================

# writeback_stage

Final stage of the five-stage pipeline and the producer side of the register-file write port that the decode stage consumes. Holds the MEM/WB pipeline register, selects the write-back datum, and drives `regWrite`, `WA` and `WD` into the decode-stage register file. It also exposes a forwarding tap and latches the output port.

## Interface
Parameters:
- `W`, 16, datapath width
- `N`, 3, register address width (8 registers)

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  MEM/WB load enable; 0 = hold (stall)
- `flush`  in  1  squash buffer contents
- `m_valid`  in  1  memory stage presents a real instruction
- `m_wb_signals`  in  3  {regWrite, WBsel[1:0]} from control unit
- `m_alu_result`  in  W  ALU result
- `m_mem_data`  in  W  data memory read value
- `m_in_port`  in  W  input-port sample
- `m_wa`  in  N  destination register
- `regWrite`  out  1  register-file write enable
- `WA`  out  N  register-file write address
- `WD`  out  W  register-file write data
- `fwd_valid`  out  1  forwarding tap valid
- `fwd_addr`  out  N  forwarding destination
- `fwd_data`  out  W  forwarding data (equals `WD`)
- `out_port`  out  W  registered output port

## Operation
- Buffer fields: `v`, `rw`, `sel[1:0]`, `alu`, `mem`, `inp`, `wa`, plus a `done` flag.
- Load (rising edge, `en`=1, `flush`=0): capture all `m_*` inputs; `v` ← `m_valid`; `done` ← 0.
- Hold (`en`=0, `flush`=0): fields are retained; `done` ← `v`. This makes each instruction write exactly once.
- Flush (rising edge): `v` ← 0 and `done` ← 0, regardless of `en`. Flush has priority over load.
- WBsel decode:
  - 00: ALU result
  - 01: memory data
  - 10: input port
  - 11: OUT instruction
- For OUT, `WD` = `alu`, and `out_port` ← `alu` on the next rising edge when `v`=1, `done`=0 and `sel`=11. `rw` is ignored for sel=11; no register write occurs.
- `regWrite` = `v` & `rw` & ~`done` & (`sel`≠11).
- `WA` = `wa` and `WD` = mux(`sel`). These are combinational from the buffer and are valid whenever `regWrite`=1.
- `fwd_valid` = `v` & `rw` & (`sel`≠11). It is not gated by `done`, because a held value is still forwardable. `fwd_addr` = `wa`, `fwd_data` = `WD`.

## Timing
- Latency: an instruction presented with `m_valid`=1 at edge k drives `regWrite` during cycle k→k+1. The register file commits it at the edge that ends that cycle.
- One write per instruction. A stall of any length after the load yields exactly one `regWrite` cycle.
- Back-to-back loads to the same `wa` produce two consecutive write cycles, and the later value wins.
- Reset: all buffer fields 0, `done`=0, `out_port`=0, and therefore `regWrite`=0, `WA`=0, `WD`=0, `fwd_valid`=0. Asserting reset mid-stall discards the held instruction immediately, with no write.
- `m_valid`=0 with `en`=1 loads a bubble: `regWrite`=0 and `fwd_valid`=0.

## Configuration
- `WB_RETIRE_CNT_EN` defined: adds output `retire_cnt` (W bits).
  - Reset value 0.
  - Increments by 1 on each edge where `v`=1 and `done`=0, i.e. once per retired instruction including OUT.
  - Wraps from 0xFFFF to 0.
  - Flushed bubbles are not counted.
- `WB_RETIRE_CNT_EN` undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared pipeline package holds:
  - `W` and `N`
  - WBsel encodings `WB_ALU`=2'b00, `WB_MEM`=2'b01, `WB_IN`=2'b10, `WB_OUT`=2'b11
  - the `wb_signals` bit layout {regWrite, WBsel}
- One sub-module, `mem_wb_buffer`: the MEM/WB register with `en`/`flush` and the `done` flag. The select mux and output port live in `writeback_stage`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with a loaded write → `regWrite`=0 immediately; `out_port`=0; `retire_cnt`=0.
- ALU write: `m_valid`=1, wb=3'b1_00, alu=0x1234, wa=5 → next cycle `regWrite`=1, `WA`=5, `WD`=0x1234, `fwd_valid`=1.
- Memory and input selects: wb=3'b1_01, mem=0xBEEF, wa=2 → `WD`=0xBEEF. Then wb=3'b1_10, in=0x00A5 → `WD`=0x00A5, with writes on consecutive cycles.
- Stall: load wa=3/0x0042, then `en`=0 for 4 cycles → `regWrite` high for exactly 1 cycle; `fwd_valid` high all 5 cycles; `retire_cnt` +1.
- OUT: wb=3'b1_11, alu=0x7777 → `regWrite`=0, `out_port`=0x7777 one edge later, and the value is held through subsequent bubbles.
- Flush: `flush`=1 together with `en`=1 and `m_valid`=1 → buffer empty, no write, no count. Also `retire_cnt` at 0xFFFF plus one retire → 0x0000.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg
//   Shared pipeline definitions for the write-back stage:
//   - W / N            : datapath width and register address width
//   - wb_sel_e         : WBsel encodings (ALU, MEM, IN, OUT)
//   - wb_signals_t     : control-unit write-back bundle {regWrite, WBsel[1:0]}
//   - writes_reg()     : "this buffered instruction targets the register file"
package writeback_stage_pkg;

    localparam int unsigned W = 16;
    localparam int unsigned N = 3;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_IN  = 2'b10,
        WB_OUT = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic    reg_write;
        wb_sel_e wb_sel;
    } wb_signals_t;

    // OUT instructions never write the register file, whatever rw says.
    function automatic logic writes_reg(input logic v, input logic rw, input wb_sel_e sel);
        return v & rw & (sel != WB_OUT);
    endfunction

endpackage

// File: rtl/writeback_stage_mem_wb_buffer.sv
// mem_wb_buffer
//   MEM/WB pipeline register with load enable, flush and a "done" flag.
//   Ports:
//     clk, rst                 rising-edge clock, async active-high reset
//     en                       load enable (0 = hold / stall)
//     flush                    squash contents (priority over load)
//     m_valid, m_wb_signals    instruction valid and {regWrite, WBsel}
//     m_alu_result, m_mem_data, m_in_port, m_wa   captured datapath fields
//     v, rw, sel, alu, mem, inp, wa, done          buffered fields
//   The done flag is set on the first hold edge after a valid load so that
//   a stalled instruction writes back exactly once.
module mem_wb_buffer
    import writeback_stage_pkg::*;
#(
    parameter int unsigned W = writeback_stage_pkg::W,
    parameter int unsigned N = writeback_stage_pkg::N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic         m_valid,
    input  logic [2:0]   m_wb_signals,
    input  logic [W-1:0] m_alu_result,
    input  logic [W-1:0] m_mem_data,
    input  logic [W-1:0] m_in_port,
    input  logic [N-1:0] m_wa,
    output logic         v,
    output logic         rw,
    output wb_sel_e      sel,
    output logic [W-1:0] alu,
    output logic [W-1:0] mem,
    output logic [W-1:0] inp,
    output logic [N-1:0] wa,
    output logic         done
);

    wb_signals_t wb_in;

    logic         v_q,    v_d;
    logic         rw_q,   rw_d;
    wb_sel_e      sel_q,  sel_d;
    logic [W-1:0] alu_q,  alu_d;
    logic [W-1:0] mem_q,  mem_d;
    logic [W-1:0] inp_q,  inp_d;
    logic [N-1:0] wa_q,   wa_d;
    logic         done_q, done_d;

    assign wb_in = wb_signals_t'(m_wb_signals);

    always_comb begin
        v_d    = v_q;
        rw_d   = rw_q;
        sel_d  = sel_q;
        alu_d  = alu_q;
        mem_d  = mem_q;
        inp_d  = inp_q;
        wa_d   = wa_q;
        done_d = done_q;
        if (flush) begin
            v_d    = 1'b0;
            done_d = 1'b0;
        end else if (en) begin
            v_d    = m_valid;
            rw_d   = wb_in.reg_write;
            sel_d  = wb_in.wb_sel;
            alu_d  = m_alu_result;
            mem_d  = m_mem_data;
            inp_d  = m_in_port;
            wa_d   = m_wa;
            done_d = 1'b0;
        end else begin
            done_d = v_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= 1'b0;
            rw_q   <= 1'b0;
            sel_q  <= WB_ALU;
            alu_q  <= '0;
            mem_q  <= '0;
            inp_q  <= '0;
            wa_q   <= '0;
            done_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            rw_q   <= rw_d;
            sel_q  <= sel_d;
            alu_q  <= alu_d;
            mem_q  <= mem_d;
            inp_q  <= inp_d;
            wa_q   <= wa_d;
            done_q <= done_d;
        end
    end

    assign v    = v_q;
    assign rw   = rw_q;
    assign sel  = sel_q;
    assign alu  = alu_q;
    assign mem  = mem_q;
    assign inp  = inp_q;
    assign wa   = wa_q;
    assign done = done_q;

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage: MEM/WB register, write-back select, register-file
//   write port, forwarding tap and registered output port.
//   Ports:
//     clk, rst          rising-edge clock, async active-high reset
//     en, flush         MEM/WB load enable / squash
//     m_*               memory-stage instruction fields
//     regWrite, WA, WD  register-file write port (WD/WA combinational)
//     fwd_valid/addr/data  forwarding tap (not gated by done)
//     out_port          latched on an OUT instruction's single active cycle
//     retire_cnt        only when WB_RETIRE_CNT_EN is defined: wrapping count
//                       of retired instructions (including OUT)
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned W = writeback_stage_pkg::W,
    parameter int unsigned N = writeback_stage_pkg::N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic         m_valid,
    input  logic [2:0]   m_wb_signals,
    input  logic [W-1:0] m_alu_result,
    input  logic [W-1:0] m_mem_data,
    input  logic [W-1:0] m_in_port,
    input  logic [N-1:0] m_wa,
    output logic         regWrite,
    output logic [N-1:0] WA,
    output logic [W-1:0] WD,
    output logic         fwd_valid,
    output logic [N-1:0] fwd_addr,
    output logic [W-1:0] fwd_data,
    output logic [W-1:0] out_port
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [W-1:0] retire_cnt
`endif
);

    logic         b_v;
    logic         b_rw;
    wb_sel_e      b_sel;
    logic [W-1:0] b_alu;
    logic [W-1:0] b_mem;
    logic [W-1:0] b_inp;
    logic [N-1:0] b_wa;
    logic         b_done;

    logic         retire;
    logic [W-1:0] wd_mux;
    logic [W-1:0] out_port_q, out_port_d;

    mem_wb_buffer #(
        .W (W),
        .N (N)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_wb_signals (m_wb_signals),
        .m_alu_result (m_alu_result),
        .m_mem_data   (m_mem_data),
        .m_in_port    (m_in_port),
        .m_wa         (m_wa),
        .v            (b_v),
        .rw           (b_rw),
        .sel          (b_sel),
        .alu          (b_alu),
        .mem          (b_mem),
        .inp          (b_inp),
        .wa           (b_wa),
        .done         (b_done)
    );

    // An instruction is active (retiring) for exactly one cycle: valid and
    // not yet marked done by a hold edge.
    assign retire = b_v & ~b_done;

    always_comb begin
        wd_mux = b_alu;
        unique case (b_sel)
            WB_ALU:  wd_mux = b_alu;
            WB_MEM:  wd_mux = b_mem;
            WB_IN:   wd_mux = b_inp;
            WB_OUT:  wd_mux = b_alu;
            default: wd_mux = b_alu;
        endcase
    end

    always_comb begin
        regWrite  = writes_reg(b_v, b_rw, b_sel) & ~b_done;
        WA        = b_wa;
        WD        = wd_mux;
        fwd_valid = writes_reg(b_v, b_rw, b_sel);
        fwd_addr  = b_wa;
        fwd_data  = wd_mux;
    end

    always_comb begin
        out_port_d = out_port_q;
        if (retire && (b_sel == WB_OUT)) begin
            out_port_d = b_alu;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_port_q <= '0;
        end else begin
            out_port_q <= out_port_d;
        end
    end

    assign out_port = out_port_q;

`ifdef WB_RETIRE_CNT_EN
    logic [W-1:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule
